uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver for the serial link driven by the core's TXD line (8N1, LSB first).
- Samples an asynchronous serial line and reassembles bytes.
- Buffers received bytes in a small show-ahead FIFO read by the CPU-side bus logic.
- Reports framing and overrun errors as sticky flags.

Parameters:
- CLK_FREQ, 27000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (234 at defaults); must be >= 8.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rd_en  input  1  pop the FIFO head; ignored when rd_valid=0.
- clear_err  input  1  clears the sticky error flags.
- rd_data  output  8  FIFO head byte; valid while rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset:
  - Applies asynchronously when reset=1.
  - All outputs 0; rd_data 0; FIFO empty; FSM in IDLE.
  - Synchronizer flops preset to 1 (line idle).
  - Reset asserted mid-frame aborts the frame; the partial byte is never pushed.
- Input sync: rx passes through a 2-flop synchronizer; rx_s is the second flop. All FSM decisions use rx_s.
- Bit counter: a baud counter runs 0..CLKS_PER_BIT-1 in every state except IDLE.
- FSM:
  - IDLE: waits for rx_s=0. Then clears the counter and goes to START.
  - START: at counter = CLKS_PER_BIT/2-1 (mid start bit), re-samples rx_s.
    - 0: clear counter, bit index=0, go to DATA.
    - 1: glitch; back to IDLE with no flags set.
  - DATA: at each counter = CLKS_PER_BIT-1 (bit centre), shifts rx_s into shift[7] (right shift, LSB first). After bit index 7, go to STOP.
  - STOP: at the bit centre, samples rx_s.
    - 1: push the byte; go to IDLE.
    - 0: set frame_err, discard the byte, go to BREAK.
  - BREAK: waits for rx_s=1, then goes to IDLE. A held-low line produces exactly one frame error.
- Latency: rd_valid rises on the clock after the stop-bit centre sample. That is ~9.5 bit times plus 2 sync cycles after the start edge.
- FIFO behaviour:
  - Show-ahead: rd_data always presents the head entry.
  - rd_en with rd_valid=1 advances the head on the clock edge.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are distinguished by the MSB.
  - Push while full, no pop: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Push and pop in the same cycle while empty: push only; the pop is ignored.
- Error flags:
  - frame_err and overrun stay set until clear_err=1 for one cycle.
  - If clear_err coincides with a new error event, the flag remains set (set wins).
- Back-to-back frames: a start edge is accepted in the first IDLE cycle after a stop bit. Consecutive bytes with no idle gap are received.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampling an even-parity bit at its centre.
  - Adds output port parity_err (1 bit, sticky, cleared by clear_err, set wins).
  - Mismatch: set parity_err and discard the byte after a valid stop bit.
  - Frame length is 11 bit times.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Test Plan (CLK_FREQ=1600000, BAUD=100000, i.e. 16 clocks/bit; FIFO_DEPTH=4):
- Reset released, rx held 1 for 200 cycles -> rd_valid=0, frame_err=0, overrun=0, rd_data=0x00.
- Send 0xA5 (8N1) -> rd_valid=1 one cycle after the stop centre sample, rd_data=0xA5. rd_en for 1 cycle -> rd_valid=0.
- Send 0x01,0x02,0x03,0x04,0x05 back-to-back without popping -> fifo_full=1, overrun=1. Four pops return 0x01..0x04. clear_err -> overrun=0.
- rx low pulse of 5 cycles, then high -> FSM returns to IDLE, no byte pushed, no flags.
- Send 0x3C with stop bit forced 0, then line held low 40 cycles, then 0x55 sent -> frame_err=1, only 0x55 appears in the FIFO.
- With UART_RX_PARITY_EN: send 0x07 with parity=1 -> rd_data=0x07. Send 0x07 with parity=0 -> parity_err=1, no push.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with show-ahead receive FIFO and sticky error flags.
// Ports: clk, reset (async, active-high), rx (serial line, idles high),
//        rd_en (pop head), clear_err (clear sticky flags),
//        rd_data (head byte), rd_valid (FIFO not empty), fifo_full,
//        frame_err, overrun, parity_err (only with UART_RX_PARITY_EN).
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clear_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic push, ferr_set;
  logic [AW:0] wp, rp;
  logic [7:0] mem [FIFO_DEPTH];
  logic empty, full, pop, wr;
`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_n, perr_set;
`endif
  assign rx_s = sync[1];
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || cnt == LAST) ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    push = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_set = 1'b0;
`endif
    case (state)
      IDLE: if (!rx_s) state_n = START;
      START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        shift_n = {rx_s, shift[7:1]};
        idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == LAST) begin
        par_bad_n = rx_s ^ (^shift);
        state_n = STOP;
      end
`endif
      STOP: if (cnt == LAST) begin
        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
          push = !par_bad;
          perr_set = par_bad;
`else
          push = 1'b1;
`endif
          state_n = IDLE;
        end else begin
          ferr_set = 1'b1;
          state_n = BRK;
        end
      end
      BRK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr = push && (!full || pop);
  assign rd_valid = !empty;
  assign fifo_full = full;
  assign rd_data = empty ? 8'h00 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= shift;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sync <= 2'b11;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      wp <= '0;
      rp <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sync <= {sync[0], rx};
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      frame_err <= (frame_err && !clear_err) || ferr_set;
      overrun <= (overrun && !clear_err) || (push && full && !pop);
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
      parity_err <= (parity_err && !clear_err) || perr_set;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit, FIFO_DEPTH 4.
module tb_uart_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic rd_en = 1'b0;
  logic clear_err = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, fifo_full, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  int vectors = 0;
  int errs = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  uart_rx #(.CLK_FREQ(1600000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clear_err(clear_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_full(fifo_full),
    .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );
  always @(negedge clk) begin
    if (!reset && rd_en && rd_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL pop_unexpected: got %02h, required nothing queued", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errs++;
          $display("FAIL pop_data: got %02h, required %02h", rd_data, e);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %02h, required %02h", name, got, want);
    end
  endtask
  task automatic bit_time(input logic v);
    rx = v;
    repeat (16) tick();
  endtask
  // stop level is left on the line afterwards; lat checks rd_valid around the stop-centre sample
  task automatic send(input logic [7:0] b, input logic stop, input logic par, input logic lat);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par);
`endif
    rx = stop;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (lat && i == 10) check("latency_before", {7'd0, rd_valid}, 8'h00);
      if (lat && i == 11) check("latency_at", {7'd0, rd_valid}, 8'h01);
    end
  endtask
  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
    tick();
  endtask
  task automatic clr();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    repeat (200) tick();
    check("reset_valid", {7'd0, rd_valid}, 8'h00);
    check("reset_full", {7'd0, fifo_full}, 8'h00);
    check("reset_frame", {7'd0, frame_err}, 8'h00);
    check("reset_overrun", {7'd0, overrun}, 8'h00);
    check("reset_data", rd_data, 8'h00);
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, ^8'hA5, 1'b1);
    check("a5_data", rd_data, 8'hA5);
    pop_n(1);
    check("a5_empty", {7'd0, rd_valid}, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i <= 4) exp_q.push_back(b);
      send(b, 1'b1, ^b, 1'b0);
    end
    check("burst_full", {7'd0, fifo_full}, 8'h01);
    check("burst_overrun", {7'd0, overrun}, 8'h01);
    check("burst_head", rd_data, 8'h01);
    pop_n(4);
    check("burst_drained", {7'd0, rd_valid}, 8'h00);
    clr();
    check("overrun_cleared", {7'd0, overrun}, 8'h00);
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (40) tick();
    check("glitch_valid", {7'd0, rd_valid}, 8'h00);
    check("glitch_frame", {7'd0, frame_err}, 8'h00);
    check("glitch_overrun", {7'd0, overrun}, 8'h00);
    send(8'h3C, 1'b0, ^8'h3C, 1'b0);
    repeat (40) tick();
    check("break_frame", {7'd0, frame_err}, 8'h01);
    check("break_nopush", {7'd0, rd_valid}, 8'h00);
    rx = 1'b1;
    repeat (20) tick();
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, ^8'h55, 1'b0);
    check("after_break_data", rd_data, 8'h55);
    pop_n(1);
    check("after_break_single", {7'd0, rd_valid}, 8'h00);
    clr();
    check("frame_cleared", {7'd0, frame_err}, 8'h00);
`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b1, 1'b0);
    check("parity_ok_data", rd_data, 8'h07);
    check("parity_ok_flag", {7'd0, parity_err}, 8'h00);
    pop_n(1);
    send(8'h07, 1'b1, 1'b0, 1'b0);
    check("parity_bad_flag", {7'd0, parity_err}, 8'h01);
    check("parity_bad_nopush", {7'd0, rd_valid}, 8'h00);
    clr();
    check("parity_cleared", {7'd0, parity_err}, 8'h00);
`endif
    repeat (5) tick();
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
